sm_register_cell: RTL and testbench
===================================

// Module: sm_register_cell
// PURPOSE
//  Generic parameterised storage register: the single flop primitive behind
//  sm_register (load every cycle) and sm_register_we (load only when enabled).
//  Used throughout the core and the VGA debug path for counters, coordinates,
//  address pointers and clock-enable toggles.
//  One clock domain; asynchronous active-low reset returns the stored value
//  to a known constant.
// PARAMETERS
//  WIDTH        32   data width in bits (>=1)
//  RESET_VALUE  0    value loaded into q while rst_n is low (WIDTH bits, zero-extended)
//  USE_WE       1    1: load gated by we (sm_register_we form); 0: we ignored, load every cycle (sm_register form)
// PORTS
//  clk    input   1      system clock, rising edge active
//  rst_n  input   1      asynchronous active-low reset
//  we     input   1      write enable; ignored when USE_WE=0 (tie 1'b1 in that case)
//  d      input   WIDTH  next value
//  q      output  WIDTH  stored value (registered output, no combinational path from d)
// BEHAVIOUR
//  - Reset: rst_n low forces q=RESET_VALUE immediately, independent of clk;
//    q holds RESET_VALUE for as long as rst_n is low, whatever clk, we and d do.
//  - Reset release: the first rising clk edge with rst_n high may load.
//    Release coincident with an edge does not load on that edge.
//  - Load (USE_WE=1): on rising clk with rst_n high and we=1, q<=d; with we=0, q holds.
//  - Load (USE_WE=0): on rising clk with rst_n high, q<=d every cycle.
//  - Latency: exactly one clock from d/we sampled to q updated; no bypass.
//  - Width rules: d and q are exactly WIDTH bits. Connecting a narrower or wider net
//    at the instance truncates or zero-extends per Verilog rules. The block does no
//    sign extension. RESET_VALUE is truncated to WIDTH.
//  - Unknown we (X/Z) while rst_n high: q becomes X. Simulation only; no recovery
//    logic is required.
//  - Feedback use: q may drive d through logic (e.g. d=~q toggles each enabled
//    cycle, d=q+1 counts). The register must not create a combinational loop.
//  - No initial blocks are relied on for function; reset is the only defined start state.
//  - Synthesises to WIDTH D-flops with async clear/preset and, for USE_WE=1, a
//    clock-enable or hold mux.
// TESTING
//  1. Async reset: load d=32'hDEADBEEF, drive rst_n low mid-cycle (no clk edge)
//     -> q=0 immediately; stays 0 for 3 edges with we=1, d=32'hFFFFFFFF.
//  2. Enable gating (USE_WE=1, WIDTH=12): we=1, d=12'h27F -> q=12'h27F after one edge;
//     we=0, d=12'h001 for 5 edges -> q stays 12'h27F.
//  3. No-enable form (USE_WE=0, WIDTH=1): d=~q after reset release
//     -> q toggles 0,1,0,1 on successive edges (clock-enable generator).
//  4. Counter with wrap (WIDTH=3): d=q+1, we=1 for 9 edges
//     -> q runs 1..7,0,1; with we toggling 1/0, q advances on alternate edges only.
//  5. RESET_VALUE=5'h1F, WIDTH=5: assert rst_n low -> q=5'h1F.
//     Release coincident with a clk edge and d=0 -> q still 5'h1F after that edge,
//     0 after the next edge.
//  6. Random d/we/rst_n for 10k cycles vs reference model -> no mismatch;
//     reset-mid-load cases (rst_n falls while we=1) always yield RESET_VALUE.

Source files
------------

// File: rtl/sm_register_cell_if.sv
// ----------------------------------------------------------------------------
// sm_register_cell_if
//   Bundles the data-side signals of one storage register.
//   master : drives we / d, observes q   (the logic feeding the register)
//   slave  : observes we / d, drives q   (the register itself)
// Signals
//   we  1      write enable (ignored by the USE_WE=0 form)
//   d   WIDTH  next value
//   q   WIDTH  stored value
// ----------------------------------------------------------------------------
interface sm_register_cell_if #(
   parameter int unsigned WIDTH = 32
);
   logic             we;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (output we, output d, input  q);
   modport slave  (input  we, input  d, output q);
endinterface

// File: rtl/sm_register_cell.sv
// ----------------------------------------------------------------------------
// sm_register_cell
//   Parameterised storage register. USE_WE=1 gives the load-when-enabled
//   form; USE_WE=0 loads every rising edge and ignores we.
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset, q <= RESET_VALUE
//   bus    slave       we / d in, q out (see sm_register_cell_if)
// Parameters
//   WIDTH        data width (>=1); must match the interface instance
//   RESET_VALUE  reset value, truncated to WIDTH by its declared type
//   USE_WE       1: gated load, 0: free-running load
// q is a pure flop output, so q -> logic -> d feedback never forms a
// combinational loop through this cell.
// ----------------------------------------------------------------------------
module sm_register_cell #(
   parameter int unsigned          WIDTH       = 32,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
   parameter bit                   USE_WE      = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   sm_register_cell_if.slave  bus
);

   logic [WIDTH-1:0] q_r;
   logic             load;

   // Free-running form ties the enable high so the flop reduces to a plain D.
   generate
      if (USE_WE) begin : g_we
         assign load = bus.we;
      end else begin : g_no_we
         assign load = 1'b1;
      end
   endgenerate

   // Hold expressed as a mux rather than an if, so an unknown enable
   // propagates unknowns into q in simulation instead of silently holding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_r <= RESET_VALUE;
      else        q_r <= load ? bus.d : q_r;
   end

   assign bus.q = q_r;

endmodule

// File: tb/tb_sm_register_cell.sv
// ----------------------------------------------------------------------------
// tb_sm_register_cell
//   Five register instances in different configurations. Stimulus pushes
//   expected q values tagged with the sample slot at which they must hold;
//   a monitor samples every half cycle (posedge+1, negedge) and pops/compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sm_register_cell;

   logic       clk = 1'b0;
   logic [4:0] rst_n_v;

   always #5 clk = ~clk;

   sm_register_cell_if #(.WIDTH(32)) if0 ();
   sm_register_cell_if #(.WIDTH(12)) if1 ();
   sm_register_cell_if #(.WIDTH(1))  if2 ();
   sm_register_cell_if #(.WIDTH(3))  if3 ();
   sm_register_cell_if #(.WIDTH(5))  if4 ();

   sm_register_cell #(.WIDTH(32), .RESET_VALUE(32'h0),  .USE_WE(1'b1))
      u0 (.clk(clk), .rst_n(rst_n_v[0]), .bus(if0));
   sm_register_cell #(.WIDTH(12), .RESET_VALUE(12'h0),  .USE_WE(1'b1))
      u1 (.clk(clk), .rst_n(rst_n_v[1]), .bus(if1));
   sm_register_cell #(.WIDTH(1),  .RESET_VALUE(1'b0),   .USE_WE(1'b0))
      u2 (.clk(clk), .rst_n(rst_n_v[2]), .bus(if2));
   sm_register_cell #(.WIDTH(3),  .RESET_VALUE(3'h0),   .USE_WE(1'b1))
      u3 (.clk(clk), .rst_n(rst_n_v[3]), .bus(if3));
   sm_register_cell #(.WIDTH(5),  .RESET_VALUE(5'h1F),  .USE_WE(1'b1))
      u4 (.clk(clk), .rst_n(rst_n_v[4]), .bus(if4));

   // Feedback users: toggle generator and 3-bit counter.
   assign if2.we = 1'b1;
   assign if2.d  = ~if2.q;
   assign if3.d  = if3.q + 3'd1;

   typedef struct {
      int          id;
      logic [31:0] exp;
      int          tag;
      string       name;
   } sb_t;

   sb_t sb[$];
   int  phase    = 0;
   int  compared = 0;
   int  mism     = 0;

   function automatic logic [31:0] get_q(int id);
      case (id)
         0:       return if0.q;
         1:       return {20'h0, if1.q};
         2:       return {31'h0, if2.q};
         3:       return {29'h0, if3.q};
         default: return {27'h0, if4.q};
      endcase
   endfunction

   task automatic drain();
      sb_t         e;
      logic [31:0] act;
      while (sb.size() != 0 && sb[0].tag <= phase) begin
         e   = sb.pop_front();
         act = get_q(e.id);
         compared++;
         if (act !== e.exp) begin
            mism++;
            $display("FAIL %s (dut%0d slot %0d): q=%h expected %h", e.name, e.id, e.tag, act, e.exp);
         end
      end
   endtask

   // Monitor: sample slots alternate posedge+1 and negedge.
   initial begin
      forever begin
         @(posedge clk); #1; phase++; drain();
         @(negedge clk);     phase++; drain();
      end
   end

   task automatic push(int id, logic [31:0] exp, int tag, string name);
      sb_t e;
      e.id = id; e.exp = exp; e.tag = tag; e.name = name;
      sb.push_back(e);
   endtask

   // Stimulus lives at posedge+2: phase+1 = before next edge, phase+2 = after it.
   task automatic tick();
      @(posedge clk); #2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m;
      logic [2:0]  cnt;
      logic        r, w;
      logic [31:0] dd;

      rst_n_v = '0;
      if0.we = 1'b0; if0.d = '0;
      if1.we = 1'b0; if1.d = '0;
      if3.we = 1'b0;
      if4.we = 1'b0; if4.d = '0;

      // Reset state, including under active clocking.
      tick(); tick();
      push(0, 32'h0,  phase+1, "rst_u0");
      push(1, 32'h0,  phase+1, "rst_u1");
      push(2, 32'h0,  phase+1, "rst_u2");
      push(3, 32'h0,  phase+1, "rst_u3");
      push(4, 32'h1F, phase+1, "rst_u4");
      tick();
      rst_n_v[1] = 1'b1; rst_n_v[3] = 1'b1; rst_n_v[4] = 1'b1;

      // 1. Async reset mid-cycle.
      rst_n_v[0] = 1'b1; if0.we = 1'b1; if0.d = 32'hDEADBEEF;
      push(0, 32'hDEADBEEF, phase+2, "t1_load");
      tick();
      rst_n_v[0] = 1'b0; if0.d = 32'hFFFFFFFF;
      push(0, 32'h0, phase+1, "t1_async");
      repeat (3) begin
         push(0, 32'h0, phase+2, "t1_hold");
         tick();
      end

      // 2. Enable gating, 12 bits.
      if1.we = 1'b1; if1.d = 12'h27F;
      push(1, 32'h27F, phase+2, "t2_load");
      tick();
      if1.we = 1'b0; if1.d = 12'h001;
      repeat (5) begin
         push(1, 32'h27F, phase+2, "t2_hold");
         tick();
      end

      // 3. Free-running toggle.
      rst_n_v[2] = 1'b1;
      push(2, 32'h0, phase+1, "t3_release");
      for (int i = 0; i < 4; i++) begin
         push(2, (i % 2 == 0) ? 32'h1 : 32'h0, phase+2, "t3_toggle");
         tick();
      end

      // 4. Counter wrap, then alternate enable.
      if3.we = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         push(3, i & 7, phase+2, "t4_count");
         tick();
      end
      cnt = 3'd1;
      for (int i = 0; i < 8; i++) begin
         if3.we = (i % 2 == 0);
         if (if3.we) cnt = cnt + 3'd1;
         push(3, {29'h0, cnt}, phase+2, "t4_alt");
         tick();
      end
      if3.we = 1'b0;

      // 5. Non-zero reset value, release coincident with an edge.
      if4.we = 1'b1; if4.d = 5'h0A;
      push(4, 32'h0A, phase+2, "t5_load");
      tick();
      rst_n_v[4] = 1'b0; if4.d = 5'h00;
      push(4, 32'h1F, phase+1, "t5_async");
      push(4, 32'h1F, phase+2, "t5_held");
      tick();
      push(4, 32'h1F, phase+2, "t5_release_edge");
      // Nonblocking release lands after the flop has evaluated this edge,
      // modelling release exactly at the edge without a simulator race.
      @(posedge clk); rst_n_v[4] <= 1'b1; #2;
      push(4, 32'h0, phase+2, "t5_first_load");
      tick();

      // 6. Random d/we/rst_n on the 32-bit instance against a reference model.
      m = 32'h0;
      for (int i = 0; i < 10000; i++) begin
         r  = ($urandom_range(0, 15) != 0);
         w  = $urandom_range(0, 1) != 0;
         dd = $urandom();
         rst_n_v[0] = r; if0.we = w; if0.d = dd;
         if (!r) begin
            m = 32'h0;
            push(0, m, phase+1, "t6_async");
         end else if (w) begin
            m = dd;
         end
         push(0, m, phase+2, "t6_rand");
         tick();
      end

      repeat (4) tick();
      if (sb.size() != 0) begin
         mism++;
         $display("FAIL drain: %0d entries pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
